fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the memory.
// Only one request is ever outstanding, and req/addr stay stable until rvalid.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry skid
// buffer behind the IF/ID output register, and branch redirect/flush.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RST   | leaving reset, no request issued yet
// S_FETCH | request to fetch_pc outstanding
// S_HALT  | output and skid both full, no request
// S_DROP  | stale request outstanding, its response is discarded
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    input  logic              id_stall,
    fetch_unit_if.master      imem,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [31:0]       if_instr
);
    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t            r_state, w_state;
    logic [XLEN-1:0]   r_fetch_pc, w_fetch_pc;
    logic [XLEN-1:0]   r_redirect_pc, w_redirect_pc;
    logic              r_if_valid, w_if_valid;
    logic [XLEN-1:0]   r_if_pc, w_if_pc;
    logic [31:0]       r_if_instr, w_if_instr;
    logic              r_skid_valid, w_skid_valid;
    logic [XLEN-1:0]   r_skid_pc, w_skid_pc;
    logic [31:0]       r_skid_instr, w_skid_instr;

    logic              w_consume;
    logic [XLEN-1:0]   w_target;

    assign w_consume = r_if_valid & ~id_stall;
    assign w_target  = branch_target & ~XLEN'(3);

    always_comb begin
        w_state       = r_state;
        w_fetch_pc    = r_fetch_pc;
        w_redirect_pc = r_redirect_pc;
        w_if_valid    = r_if_valid & ~w_consume;
        w_if_pc       = r_if_pc;
        w_if_instr    = r_if_instr;
        w_skid_valid  = r_skid_valid;
        w_skid_pc     = r_skid_pc;
        w_skid_instr  = r_skid_instr;

        // A redirect flushes everything already fetched, stalled or not.
        if (branch_taken) begin
            w_if_valid   = 1'b0;
            w_skid_valid = 1'b0;
        end

        case (r_state)
            S_RST: begin
                w_state = S_FETCH;
                if (branch_taken) w_fetch_pc = w_target;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    if (imem.imem_rvalid) begin
                        w_fetch_pc = w_target;
                    end else begin
                        w_redirect_pc = w_target;
                        w_state       = S_DROP;
                    end
                end else if (imem.imem_rvalid) begin
                    w_fetch_pc = r_fetch_pc + XLEN'(4);
                    if (!r_if_valid || w_consume) begin
                        w_if_valid = 1'b1;
                        w_if_pc    = r_fetch_pc;
                        w_if_instr = imem.imem_rdata;
                    end else begin
                        w_skid_valid = 1'b1;
                        w_skid_pc    = r_fetch_pc;
                        w_skid_instr = imem.imem_rdata;
                        w_state      = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (branch_taken) begin
                    w_fetch_pc = w_target;
                    w_state    = S_FETCH;
                end else if (!id_stall) begin
                    w_if_valid   = 1'b1;
                    w_if_pc      = r_skid_pc;
                    w_if_instr   = r_skid_instr;
                    w_skid_valid = 1'b0;
                    w_state      = S_FETCH;
                end
            end
            S_DROP: begin
                if (branch_taken) w_redirect_pc = w_target;
                if (imem.imem_rvalid) begin
                    w_fetch_pc = branch_taken ? w_target : r_redirect_pc;
                    w_state    = S_FETCH;
                end
            end
            default: w_state = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RST;
            r_fetch_pc    <= RESET_PC;
            r_redirect_pc <= '0;
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_instr    <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_pc     <= '0;
            r_skid_instr  <= '0;
        end else begin
            r_state       <= w_state;
            r_fetch_pc    <= w_fetch_pc;
            r_redirect_pc <= w_redirect_pc;
            r_if_valid    <= w_if_valid;
            r_if_pc       <= w_if_pc;
            r_if_instr    <= w_if_instr;
            r_skid_valid  <= w_skid_valid;
            r_skid_pc     <= w_skid_pc;
            r_skid_instr  <= w_skid_instr;
        end
    end

    // DROP keeps the stale request on the bus until its response returns.
    assign imem.imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
    assign imem.imem_addr = r_fetch_pc;

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/skid, redirects, PC wrap
// and reset mid-stream, with expected values written out by hand.
module tb_fetch_unit;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            id_stall;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_stall      (id_stall),
        .imem          (bus.master),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [XLEN-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (memory answers for the address on the bus), then sample after the edge.
    task automatic cyc(input logic br, input logic [XLEN-1:0] tgt, input logic rv);
        branch_taken     = br;
        branch_target    = tgt;
        bus.imem_rvalid  = rv;
        bus.imem_rdata   = mem(bus.imem_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        id_stall        = 1'b0;
        branch_taken    = 1'b0;
        branch_target   = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        #1;

        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("rst_req",   64'(bus.imem_req), 64'd0);
        chk("rst_valid", 64'(if_valid), 64'd0);
        chk("rst_pc",    64'(if_pc), 64'd0);
        chk("rst_instr", 64'(if_instr), 64'd0);

        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        chk("first_req",  64'(bus.imem_req), 64'd1);
        chk("first_addr", 64'(bus.imem_addr), 64'h0);

        // back-to-back stream
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("stream_valid", 64'(if_valid), 64'd1);
            chk("stream_pc",    64'(if_pc), 64'(32'(4 * k)));
            chk("stream_instr", 64'(if_instr), 64'(mem(32'(4 * k))));
        end
        chk("stream_addr", 64'(bus.imem_addr), 64'h14);

        // stall: response for 0x14 goes to skid, unit halts
        id_stall = 1'b1;
        cyc(1'b0, 32'h0, 1'b1);
        chk("halt_req", 64'(bus.imem_req), 64'd0);
        chk("halt_pc",  64'(if_pc), 64'h10);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("halt_req2",   64'(bus.imem_req), 64'd0);
        chk("halt_valid2", 64'(if_valid), 64'd1);
        chk("halt_pc2",    64'(if_pc), 64'h10);
        id_stall = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        chk("skid_valid", 64'(if_valid), 64'd1);
        chk("skid_pc",    64'(if_pc), 64'h14);
        chk("skid_instr", 64'(if_instr), 64'(mem(32'h14)));
        chk("resume_req",  64'(bus.imem_req), 64'd1);
        chk("resume_addr", 64'(bus.imem_addr), 64'h18);
        cyc(1'b0, 32'h0, 1'b1);
        chk("after_skid_pc", 64'(if_pc), 64'h18);
        cyc(1'b0, 32'h0, 1'b1);
        chk("pc_1c",   64'(if_pc), 64'h1C);
        chk("addr_20", 64'(bus.imem_addr), 64'h20);

        // redirect to 0x100 while 0x20 is outstanding
        cyc(1'b1, 32'h100, 1'b0);
        chk("drop_valid", 64'(if_valid), 64'd0);
        chk("drop_req",   64'(bus.imem_req), 64'd1);
        chk("drop_addr",  64'(bus.imem_addr), 64'h20);
        cyc(1'b0, 32'h0, 1'b0);
        chk("drop_addr2", 64'(bus.imem_addr), 64'h20);
        cyc(1'b0, 32'h0, 1'b1);
        chk("drop_discard", 64'(if_valid), 64'd0);
        chk("redir_addr",   64'(bus.imem_addr), 64'h100);
        cyc(1'b0, 32'h0, 1'b1);
        chk("redir_valid", 64'(if_valid), 64'd1);
        chk("redir_pc",    64'(if_pc), 64'h100);
        chk("redir_instr", 64'(if_instr), 64'(mem(32'h100)));

        // redirect coinciding with a response, unaligned target
        cyc(1'b1, 32'h203, 1'b1);
        chk("same_valid", 64'(if_valid), 64'd0);
        chk("same_addr",  64'(bus.imem_addr), 64'h200);
        cyc(1'b0, 32'h0, 1'b1);
        chk("same_pc", 64'(if_pc), 64'h200);

        // PC wrap
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_addr0", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_pc",   64'(if_pc), 64'hFFFF_FFFC);
        chk("wrap_addr", 64'(bus.imem_addr), 64'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_pc0", 64'(if_pc), 64'h0);

        // second redirect while dropping overrides the first
        cyc(1'b1, 32'h40, 1'b0);
        cyc(1'b1, 32'h80, 1'b0);
        chk("drop2_addr", 64'(bus.imem_addr), 64'h4);
        cyc(1'b0, 32'h0, 1'b1);
        chk("drop2_valid", 64'(if_valid), 64'd0);
        chk("drop2_redir", 64'(bus.imem_addr), 64'h80);
        cyc(1'b0, 32'h0, 1'b1);
        chk("drop2_pc", 64'(if_pc), 64'h80);

        // redirect in HALT while stalled flushes output and skid
        id_stall = 1'b1;
        cyc(1'b0, 32'h0, 1'b1);
        chk("halt2_req", 64'(bus.imem_req), 64'd0);
        cyc(1'b1, 32'h300, 1'b0);
        chk("hbr_valid", 64'(if_valid), 64'd0);
        chk("hbr_req",   64'(bus.imem_req), 64'd1);
        chk("hbr_addr",  64'(bus.imem_addr), 64'h300);
        cyc(1'b0, 32'h0, 1'b1);
        chk("hbr_pc", 64'(if_pc), 64'h300);
        id_stall = 1'b0;
        cyc(1'b0, 32'h0, 1'b1);
        chk("hbr_next_pc", 64'(if_pc), 64'h304);

        // reset with skid full
        id_stall = 1'b1;
        cyc(1'b0, 32'h0, 1'b1);
        chk("pre_rst_req", 64'(bus.imem_req), 64'd0);
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        chk("mid_rst_valid", 64'(if_valid), 64'd0);
        chk("mid_rst_req",   64'(bus.imem_req), 64'd0);
        chk("mid_rst_pc",    64'(if_pc), 64'h0);
        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        chk("post_rst_req",  64'(bus.imem_req), 64'd1);
        chk("post_rst_addr", 64'(bus.imem_addr), 64'h0);
        id_stall = 1'b0;
        cyc(1'b0, 32'h0, 1'b1);
        chk("post_rst_pc",    64'(if_pc), 64'h0);
        chk("post_rst_instr", 64'(if_instr), 64'(mem(32'h0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
